// File: rtl/task_answer_unpacker.sv
// ---------------------------------------------------------------------------
// task_answer_unpacker
//
// Buffers packed answer words in a small FIFO and serialises them, least
// significant byte first, into a byte stream for a UART transmitter. The
// last word of a packet only contributes as many bytes as the packet size
// leaves over, so padding bytes are never sent. Words arriving while the
// FIFO is full are dropped and flagged with a sticky overflow bit.
//
// Parameters
//   FIFO_DEPTH  word-buffer depth in entries (power of 2, >= 4)
//   IN_WIDTH    input word width in bits (32)
//
// Ports
//   i_clk                   clock, rising edge
//   i_rst                   asynchronous active-high reset
//   i_answer_valid          input word present this cycle (no backpressure)
//   i_answer_data           packed answer word, byte 0 in bits [7:0]
//   i_answer_last           final word of the packet
//   i_answer_size_in_bytes  packet byte count, used only with a last word
//   o_byte_data             current output byte
//   o_byte_valid            output byte and its flags are valid
//   i_byte_ready            downstream accepts the byte this cycle
//   o_byte_first            byte is the first of a packet
//   o_byte_last             byte is the final byte of a packet
//   o_overflow              sticky: an input word was dropped
//   o_busy                  FIFO non-empty or a word is being unpacked
// ---------------------------------------------------------------------------
module task_answer_unpacker #(
    parameter int FIFO_DEPTH = 16,
    parameter int IN_WIDTH   = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_answer_valid,
    input  logic [IN_WIDTH-1:0] i_answer_data,
    input  logic                i_answer_last,
    input  logic [31:0]         i_answer_size_in_bytes,
    output logic [7:0]          o_byte_data,
    output logic                o_byte_valid,
    input  logic                i_byte_ready,
    output logic                o_byte_first,
    output logic                o_byte_last,
    output logic                o_overflow,
    output logic                o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NB = IN_WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [IN_WIDTH-1:0] data;
        logic                last;
        logic [2:0]          nbytes;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    entry_t             head;
    entry_t             wr_entry;
    entry_t             hold;
    logic [NB-1:0][7:0] hold_bytes;
    logic [BW-1:0]      idx;
    state_t             state;
    state_t             state_next;
    logic               first_pending;
    logic               overflow;

    logic               empty;
    logic               full;
    logic               pop;
    logic               accept;
    logic               wr_en;
    logic               drop;
    logic               word_done;
    logic [2:0]         in_nbytes;
    logic               unused_size_bits;

    // Only the low two size bits decide how many bytes the last word carries.
    assign unused_size_bits = ^i_answer_size_in_bytes[31:2];

    // Pointers carry one extra bit so equal indices can mean empty or full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Last word: ((size-1) mod 4)+1, which maps size=0 to a full word.
    always_comb begin
        in_nbytes = 3'(NB);
        if (i_answer_last) begin
            in_nbytes = (i_answer_size_in_bytes[1:0] == 2'd0) ?
                        3'd4 : {1'b0, i_answer_size_in_bytes[1:0]};
        end
    end

    assign wr_entry = '{data: i_answer_data, last: i_answer_last, nbytes: in_nbytes};

    assign hold_bytes = hold.data;
    assign word_done  = (3'(idx) == hold.nbytes - 3'd1);

    // A full FIFO still takes a word when the same edge frees an entry.
    assign wr_en = i_answer_valid && (!full || pop);
    assign drop  = i_answer_valid && full && !pop;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                accept = i_byte_ready;
                if (i_byte_ready && word_done) begin
                    // Refill straight from the FIFO so words follow without a gap.
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            hold          <= '0;
            idx           <= '0;
            first_pending <= 1'b1;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= head;
                idx    <= '0;
            end else if (accept && !word_done) begin
                idx <= idx + 1'b1;
            end
            // The byte after an accepted packet-final byte opens a new packet.
            if (accept) begin
                first_pending <= o_byte_last;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Outputs are decoded from registers only, so they hold while stalled
    // and fall to zero as soon as reset is asserted.
    assign o_byte_valid = (state == SEND);
    assign o_byte_data  = o_byte_valid ? hold_bytes[idx] : 8'h00;
    assign o_byte_first = o_byte_valid && first_pending;
    assign o_byte_last  = o_byte_valid && hold.last && word_done;
    assign o_overflow   = overflow;
    assign o_busy       = (state == SEND) || !empty;

endmodule
